// File: rtl/wbm_rr_arbiter_if.sv
// Wishbone bundle between NM masters and one shared slave, as seen across the arbiter.
// The master modport is the arbiter's view; slave is the view of the surrounding system.
interface wbm_rr_arbiter_if #(
  parameter int unsigned NM = 4,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [NM-1:0]        wbm_cyc_i;
  logic [NM-1:0]        wbm_stb_i;
  logic [NM-1:0]        wbm_we_i;
  logic [NM*AW-1:0]     wbm_adr_i;
  logic [NM*DW-1:0]     wbm_dat_i;
  logic [NM*DW/8-1:0]   wbm_sel_i;
  logic [DW-1:0]        wbm_dat_o;
  logic [NM-1:0]        wbm_ack_o;
  logic [NM-1:0]        wbm_err_o;

  logic                 wbs_cyc_o;
  logic                 wbs_stb_o;
  logic                 wbs_we_o;
  logic [AW-1:0]        wbs_adr_o;
  logic [DW-1:0]        wbs_dat_o;
  logic [DW/8-1:0]      wbs_sel_o;
  logic [DW-1:0]        wbs_dat_i;
  logic                 wbs_ack_i;
  logic                 wbs_err_i;

  modport master (
    input  wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_adr_i, wbm_dat_i, wbm_sel_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o,
    output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o, wbs_sel_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i
  );

  modport slave (
    output wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_adr_i, wbm_dat_i, wbm_sel_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o,
    input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o, wbs_sel_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i
  );
endinterface

// File: rtl/wbm_rr_arbiter.sv
// Round-robin Wishbone B4 arbiter: NM masters share one slave, grant held for the whole CYC,
// with a stall watchdog that errors out transactions the slave never answers.
module wbm_rr_arbiter #(
  parameter int unsigned NM        = 4,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic                   mclk,
  input  logic                   rst_n,
  wbm_rr_arbiter_if.master       bus,
  output logic [$clog2(NM)-1:0]  gnt_o,
  output logic                   busy_o,
  output logic                   timeout_o
);

  localparam int unsigned GW = $clog2(NM);
  localparam int unsigned CW = (TO_CYCLES > 0) ? $clog2(TO_CYCLES + 1) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBusy  = 2'd1;
  localparam logic [1:0] StAbort = 2'd2;

  localparam logic [GW-1:0] LastInit = GW'(NM - 1);
  localparam logic [CW-1:0] ToMax    = CW'(TO_CYCLES);
  localparam logic [CW-1:0] ToLast   = CW'(TO_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [GW-1:0] last_gnt_q, last_gnt_d;
  logic [CW-1:0] to_cnt_q, to_cnt_d;

  logic          cyc_g, stb_g, stall, to_fire, found;
  logic [GW-1:0] win;
  int unsigned   scan_idx;

  assign cyc_g   = bus.wbm_cyc_i[gnt_q];
  assign stb_g   = bus.wbm_stb_i[gnt_q];
  assign stall   = (state_q == StBusy) && cyc_g && stb_g && !bus.wbs_ack_i && !bus.wbs_err_i;
  assign to_fire = (TO_CYCLES != 0) && stall && (to_cnt_q == ToLast);

  // Scan from the slot after the last winner; modulo handled by subtraction so NM may be odd.
  always_comb begin
    found    = 1'b0;
    win      = gnt_q;
    scan_idx = 0;
    for (int unsigned i = 1; i <= NM; i++) begin
      scan_idx = int'(last_gnt_q) + i;
      if (scan_idx >= NM) scan_idx = scan_idx - NM;
      if (!found && bus.wbm_cyc_i[scan_idx]) begin
        found = 1'b1;
        win   = GW'(scan_idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    to_cnt_d   = '0;
    case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d      = win;
          last_gnt_d = win;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        if (!cyc_g) begin
          state_d = StIdle;
        end else if (to_fire) begin
          state_d = StAbort;
        end else if (stall) begin
          to_cnt_d = (to_cnt_q == ToMax) ? to_cnt_q : to_cnt_q + 1'b1;
        end
      end
      StAbort: begin
        if (!cyc_g) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      last_gnt_q <= LastInit;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  // Slave side and responses are only live in BUSY; IDLE and ABORT park everything at zero.
  always_comb begin
    bus.wbs_cyc_o = 1'b0;
    bus.wbs_stb_o = 1'b0;
    bus.wbs_we_o  = 1'b0;
    bus.wbs_adr_o = '0;
    bus.wbs_dat_o = '0;
    bus.wbs_sel_o = '0;
    bus.wbm_dat_o = '0;
    bus.wbm_ack_o = '0;
    bus.wbm_err_o = '0;
    if (state_q == StBusy) begin
      bus.wbs_cyc_o        = cyc_g;
      bus.wbs_stb_o        = cyc_g & stb_g & ~to_fire;
      bus.wbs_we_o         = bus.wbm_we_i[gnt_q];
      bus.wbs_adr_o        = bus.wbm_adr_i[gnt_q*AW +: AW];
      bus.wbs_dat_o        = bus.wbm_dat_i[gnt_q*DW +: DW];
      bus.wbs_sel_o        = bus.wbm_sel_i[gnt_q*(DW/8) +: (DW/8)];
      bus.wbm_dat_o        = bus.wbs_dat_i;
      bus.wbm_ack_o[gnt_q] = bus.wbs_ack_i;
      bus.wbm_err_o[gnt_q] = bus.wbs_err_i | to_fire;
    end
  end

  assign gnt_o     = gnt_q;
  assign busy_o    = (state_q == StBusy);
  assign timeout_o = to_fire;

endmodule

// File: tb/tb_wbm_rr_arbiter.sv
// Directed bench for wbm_rr_arbiter: grant order, fairness, burst hold, watchdog and reset.
module tb_wbm_rr_arbiter;
  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic       mclk;
  logic       rst_n;
  logic [1:0] gnt_o;
  logic       busy_o;
  logic       timeout_o;

  int n_tests;
  int n_fail;

  wbm_rr_arbiter_if #(.NM(NM), .AW(AW), .DW(DW)) bus ();

  wbm_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TO_CYCLES(TO)) dut (
    .mclk      (mclk),
    .rst_n     (rst_n),
    .bus       (bus),
    .gnt_o     (gnt_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  initial begin
    #1000000;
    $display("FAIL global_timeout got=hang exp=finish");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #2;
  endtask

  task automatic req(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    bus.wbm_cyc_i[m]           = 1'b1;
    bus.wbm_stb_i[m]           = 1'b1;
    bus.wbm_we_i[m]            = we;
    bus.wbm_adr_i[m*AW +: AW]  = adr;
    bus.wbm_dat_i[m*DW +: DW]  = dat;
    bus.wbm_sel_i[m*4 +: 4]    = 4'hf;
  endtask

  task automatic drop(input int m);
    bus.wbm_cyc_i[m] = 1'b0;
    bus.wbm_stb_i[m] = 1'b0;
  endtask

  // Called while BUSY with master m granted: one acked beat, then m releases CYC.
  task automatic finish_txn(input int m);
    logic [3:0] exp_ack;
    exp_ack = 4'b0001 << m;
    bus.wbs_ack_i = 1'b1;
    bus.wbs_dat_i = 32'h5500_0000 + m;
    #1;
    check("txn_ack", bus.wbm_ack_o, exp_ack);
    step();
    bus.wbs_ack_i = 1'b0;
    drop(m);
    #1;
    check("txn_cyc_drop", bus.wbs_cyc_o, 0);
    step();
    #1;
    check("txn_idle_gap", busy_o, 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.wbm_cyc_i = '0;
    bus.wbm_stb_i = '0;
    bus.wbm_we_i  = '0;
    bus.wbm_adr_i = '0;
    bus.wbm_dat_i = '0;
    bus.wbm_sel_i = '0;
    bus.wbs_dat_i = '0;
    bus.wbs_ack_i = 1'b0;
    bus.wbs_err_i = 1'b0;

    step();
    step();
    #1;
    check("rst_cyc", bus.wbs_cyc_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_gnt", gnt_o, 0);
    check("rst_ack", bus.wbm_ack_o, 0);
    check("rst_err", bus.wbm_err_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_adr", bus.wbs_adr_o, 0);
    rst_n = 1'b1;

    // All four masters request at once after reset: grants 0,1,2,3 with an idle cycle between.
    step();
    for (int i = 0; i < NM; i++) req(i, 1'b1, 32'h1000 + 32'(i * 4), 32'hA0 + 32'(i));
    #1;
    check("all_idle_first", bus.wbs_cyc_o, 0);
    for (int k = 0; k < NM; k++) begin
      step();
      #1;
      check("all_gnt", gnt_o, 64'(k));
      check("all_busy", busy_o, 1);
      check("all_adr", bus.wbs_adr_o, 64'(32'h1000 + 32'(k * 4)));
      check("all_dat", bus.wbs_dat_o, 64'(32'hA0 + 32'(k)));
      check("all_we", bus.wbs_we_o, 1);
      finish_txn(k);
    end

    // Single master 2 read with three wait states.
    req(2, 1'b0, 32'h3000_0010, 32'h0);
    #1;
    check("rd_latency_idle", bus.wbs_cyc_o, 0);
    step();
    #1;
    check("rd_cyc", bus.wbs_cyc_o, 1);
    check("rd_stb", bus.wbs_stb_o, 1);
    check("rd_gnt", gnt_o, 2);
    check("rd_adr", bus.wbs_adr_o, 32'h3000_0010);
    check("rd_we", bus.wbs_we_o, 0);
    check("rd_wait_ack", bus.wbm_ack_o, 0);
    step();
    step();
    step();
    bus.wbs_ack_i = 1'b1;
    bus.wbs_dat_i = 32'hDEAD_BEEF;
    #1;
    check("rd_data", bus.wbm_dat_o, 32'hDEAD_BEEF);
    check("rd_ack", bus.wbm_ack_o, 4'b0100);
    step();
    bus.wbs_ack_i = 1'b0;
    drop(2);
    #1;
    check("rd_cyc_drop", bus.wbs_cyc_o, 0);
    step();
    #1;
    check("rd_idle", busy_o, 0);

    // Fairness: last grant 2, masters 0 and 3 together -> 3 then 0.
    req(0, 1'b1, 32'h40, 32'h11);
    req(3, 1'b1, 32'h4c, 32'h33);
    step();
    #1;
    check("fair_first", gnt_o, 3);
    finish_txn(3);
    step();
    #1;
    check("fair_second", gnt_o, 0);
    finish_txn(0);

    // Burst hold: master 1 keeps CYC for four beats while master 0 waits.
    req(1, 1'b1, 32'h80, 32'h77);
    step();
    #1;
    check("burst_gnt", gnt_o, 1);
    req(0, 1'b1, 32'h90, 32'h99);
    for (int b = 0; b < 4; b++) begin
      bus.wbs_ack_i = 1'b1;
      #1;
      check("burst_ack", bus.wbm_ack_o, 4'b0010);
      step();
      #1;
      check("burst_hold_gnt", gnt_o, 1);
    end
    bus.wbs_ack_i = 1'b0;
    drop(1);
    #1;
    check("burst_m0_noack", bus.wbm_ack_o, 0);
    step();
    #1;
    check("burst_idle", busy_o, 0);
    step();
    #1;
    check("burst_m0_gnt", gnt_o, 0);
    finish_txn(0);

    // Watchdog: master 2 stalls 16 cycles while master 3 waits.
    req(2, 1'b0, 32'hA0, 32'h0);
    step();
    #1;
    check("to_gnt", gnt_o, 2);
    req(3, 1'b1, 32'hB0, 32'h3);
    for (int s = 1; s < TO; s++) begin
      #1;
      check("to_no_pulse", timeout_o, 0);
      check("to_stb_up", bus.wbs_stb_o, 1);
      step();
    end
    #1;
    check("to_pulse", timeout_o, 1);
    check("to_err", bus.wbm_err_o, 4'b0100);
    check("to_stb_forced", bus.wbs_stb_o, 0);
    step();
    bus.wbs_ack_i = 1'b1;
    #1;
    check("abort_busy", busy_o, 0);
    check("abort_cyc", bus.wbs_cyc_o, 0);
    check("abort_err", bus.wbm_err_o, 0);
    check("abort_pulse_gone", timeout_o, 0);
    check("abort_late_ack", bus.wbm_ack_o, 0);
    step();
    #1;
    check("abort_hold_gnt", gnt_o, 2);
    check("abort_hold_busy", busy_o, 0);
    bus.wbs_ack_i = 1'b0;
    drop(2);
    step();
    step();
    #1;
    check("abort_next_gnt", gnt_o, 3);
    check("abort_next_busy", busy_o, 1);
    finish_txn(3);

    // Reset mid-burst: outputs drop at once; master 0 has priority afterwards.
    req(1, 1'b1, 32'hC0, 32'h5);
    step();
    #1;
    check("mid_gnt", gnt_o, 1);
    bus.wbs_ack_i = 1'b1;
    #1;
    check("mid_ack", bus.wbm_ack_o, 4'b0010);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cyc", bus.wbs_cyc_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_ack", bus.wbm_ack_o, 0);
    check("mid_rst_gnt", gnt_o, 0);
    bus.wbs_ack_i = 1'b0;
    req(0, 1'b1, 32'hD0, 32'h6);
    req(3, 1'b1, 32'hDC, 32'h7);
    step();
    rst_n = 1'b1;
    step();
    #1;
    check("post_rst_gnt", gnt_o, 0);
    check("post_rst_busy", busy_o, 1);
    finish_txn(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wbm_rr_arbiter.md
Name: wbm_rr_arbiter

Overview:
- Round-robin Wishbone B4 arbiter that shares one slave port among NM masters.
- Typical masters: wb_host, risc core data port, DMA.
- Grant is held for the whole master cycle (CYC high), so block transfers are never split.
- Built-in watchdog aborts transactions that the slave never acknowledges.

Parameters:
NM, 4, number of masters (2..8)
AW, 32, address width
DW, 32, data width (multiple of 8)
TO_CYCLES, 255, stall-cycle limit before abort; 0 disables timeout

Ports:
mclk  input  1  clock
rst_n  input  1  asynchronous active-low reset
wbm_cyc_i  input  NM  per-master CYC
wbm_stb_i  input  NM  per-master STB
wbm_we_i  input  NM  per-master WE
wbm_adr_i  input  NM*AW  master i occupies bits [i*AW +: AW]
wbm_dat_i  input  NM*DW  write data, packed the same way
wbm_sel_i  input  NM*DW/8  byte selects, packed the same way
wbm_dat_o  output  DW  read data, broadcast to all masters
wbm_ack_o  output  NM  per-master ACK
wbm_err_o  output  NM  per-master ERR
wbs_cyc_o  output  1  slave CYC
wbs_stb_o  output  1  slave STB
wbs_we_o  output  1  slave WE
wbs_adr_o  output  AW  slave address
wbs_dat_o  output  DW  slave write data
wbs_sel_o  output  DW/8  slave byte selects
wbs_dat_i  input  DW  slave read data
wbs_ack_i  input  1  slave ACK
wbs_err_i  input  1  slave ERR
gnt_o  output  clog2(NM)  current grant index
busy_o  output  1  state is BUSY
timeout_o  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, gnt=0, last_gnt=NM-1 (so master 0 wins first), to_cnt=0.
  - All outputs 0.
  - Any transaction in flight is dropped immediately; no ack is generated.
- States: IDLE, BUSY, ABORT.
- IDLE:
  - If any wbm_cyc_i is set, scan indices last_gnt+1, last_gnt+2, ... modulo NM; the first one with CYC set wins.
  - Register gnt and last_gnt=winner; go to BUSY.
  - Arbitration latency: 1 cycle from master CYC to wbs_cyc_o.
  - STB and CYC do not affect priority, except that only CYC requests.
- BUSY:
  - wbs_cyc_o = wbm_cyc_i[gnt].
  - wbs_stb_o = wbm_stb_i[gnt] & wbm_cyc_i[gnt].
  - WE, ADR, DAT and SEL are combinationally muxed from master gnt.
  - wbm_dat_o = wbs_dat_i (unqualified).
  - wbm_ack_o[gnt] = wbs_ack_i; wbm_err_o[gnt] = wbs_err_i; all other ack/err bits are 0.
  - When wbm_cyc_i[gnt] falls, go to IDLE in the same cycle, with wbs_cyc_o low.
  - Minimum of one IDLE cycle between consecutive grants.
  - Requests from other masters wait; they receive no ack or err.
- Watchdog:
  - to_cnt increments each BUSY cycle in which wbs_stb_o=1 and both wbs_ack_i and wbs_err_i are 0.
  - to_cnt clears on ack, err, STB low, or leaving BUSY.
  - It saturates at TO_CYCLES.
  - When to_cnt == TO_CYCLES-1 and the stall continues:
    - wbm_err_o[gnt]=1 for exactly that cycle, timeout_o=1, and wbs_stb_o is forced to 0.
    - Next state is ABORT.
  - If wbs_ack_i arrives in that same cycle, the ack wins and no timeout occurs.
  - With TO_CYCLES=0 the watchdog is inert.
- ABORT:
  - All wbs_* outputs are 0 and all ack/err outputs are 0.
  - Wait for wbm_cyc_i[gnt]=0, then go to IDLE.
  - A late wbs_ack_i is ignored.
- gnt_o reflects the gnt register in every state. busy_o = (state==BUSY).
- In IDLE and ABORT, wbs_adr_o, wbs_dat_o, wbs_sel_o and wbs_we_o are driven to 0.
- Widths:
  - to_cnt is clog2(TO_CYCLES+1) bits.
  - The round-robin wrap is computed modulo NM, so NM need not be a power of two.

Test Plan:
- Single master: master 2 reads 0x3000_0010, slave acks after 3 wait states with 0xDEAD_BEEF → wbs_cyc_o rises 1 cycle after wbm_cyc_i[2]; wbm_dat_o=0xDEAD_BEEF with wbm_ack_o=4'b0100; gnt_o=2.
- All 4 masters assert CYC together after reset, each doing one write → grant order is 0,1,2,3, with one idle cycle between grants.
- Fairness: last grant was 2, then masters 0 and 3 request together → 3 is granted first, then 0.
- Burst hold: master 1 holds CYC for 4 acked beats while master 0 requests → master 0 is granted only after master 1 drops CYC; wbm_ack_o[0] stays 0 throughout.
- Timeout, TO_CYCLES=16: slave never acks → wbm_err_o[gnt] and timeout_o pulse on the 16th stall cycle; wbs_stb_o drops in that cycle; the arbiter stays in ABORT until the master drops CYC, then serves the next requester.
- Reset mid-burst: rst_n low while BUSY → wbs_cyc_o, busy_o and all ack outputs go to 0 immediately. After release, master 0 has first priority.
